return_stack: RTL and testbench
===============================

Name: return_stack

Overview:
- Hardware LIFO of 8-bit return addresses for the multicycle processor.
- On a call, the control FSM pushes the incremented PC. On a return, it pops that address back into the PC.
- This is the consumer side of the PC+1 path: it stores incremented addresses and hands them back one cycle after a pop request.
- Occupancy is held in an up/down counter. The block sits beside the PC register and is strobed by the control FSM.

Parameters:
DATA_W, 8, width of a stored address
PTR_W, 3, log2 of stack depth
DEPTH, 8, number of entries; must equal 2**PTR_W

Ports:
clock  input  1  system clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
push  input  1  one-cycle strobe: store data_in on top of stack
pop  input  1  one-cycle strobe: remove top of stack and present it on data_out
data_in  input  DATA_W  address to push (the incremented PC)
clear_err  input  1  clears the sticky err flag
data_out  output  DATA_W  registered popped value
out_valid  output  1  high for exactly one cycle when data_out holds a newly popped value
count  output  PTR_W+1  current occupancy, 0..DEPTH
empty  output  1  count == 0, decoded from the count register
full  output  1  count == DEPTH, decoded from the count register
err  output  1  sticky overflow/underflow flag

Behaviour:
- Reset:
  - Sampled on the clock edge and has priority over every other input, including mid-operation.
  - Values after reset: count=0, data_out=0, out_valid=0, err=0, empty=1, full=0.
  - Storage array is not cleared.
- Storage: register array mem[0..DEPTH-1]. Entry mem[count-1] is top of stack.
- out_valid defaults to 0 every cycle unless a rule below sets it.
- Push only, not full: mem[count] <= data_in; count <= count+1.
- Push only, full (overflow):
  - Write is dropped; count and mem are unchanged.
  - err <= 1.
- Pop only, not empty:
  - data_out <= mem[count-1]; out_valid <= 1; count <= count-1.
  - Latency is 1 cycle: the value is on data_out the cycle after the pop strobe, and held until the next successful pop.
- Pop only, empty (underflow):
  - data_out holds its previous value; out_valid stays 0; count stays 0.
  - err <= 1.
- Push and pop together, not empty (including full):
  - Top is replaced: data_out <= mem[count-1], mem[count-1] <= data_in, out_valid <= 1.
  - count is unchanged; no error.
- Push and pop together, empty:
  - Pass-through: data_out <= data_in; out_valid <= 1.
  - count stays 0; mem is unchanged; no error.
- err:
  - Sets on overflow or underflow and holds until clear_err or reset.
  - If clear_err and a new error occur in the same cycle, err ends at 1.
- count arithmetic:
  - PTR_W+1 bits wide.
  - Never wraps: it saturates at 0 and at DEPTH by the rules above.
  - Write/read index is the low PTR_W bits of count or count-1.
- Strobes held high for several cycles act as one operation per cycle.
- Outputs carry no combinational path from inputs; empty and full depend only on count.

Optional Feature:
- Macro: RETURN_STACK_PEEK_EN.
- When defined:
  - Adds output port top (DATA_W).
  - top is combinationally mem[count-1] when count != 0, else 0.
  - Lets the FSM read the return address without popping.
  - top updates the cycle after any push or pop.
- When undefined: port top does not exist; the rest of the behaviour is identical.

Test Plan:
- Reset mid-operation: push 0x11 and 0x22, then assert reset together with push 0x33 → next cycle count=0, empty=1, err=0, out_valid=0, data_out=0.
- Push/pop order:
  - Stimulus: push 0x05, 0x06, 0x07 on consecutive cycles, then pop three times.
  - Response: data_out shows 0x07, 0x06, 0x05, each with a one-cycle out_valid pulse one cycle after its pop; count ends at 0 and empty=1.
- Fill and overflow:
  - Stimulus: push 0x01..0x08, then push 0xFF.
  - Response: full=1 and count=8 after the 8th push; the 9th push sets err=1 with count still 8.
  - Popping eight times returns 0x08..0x01; 0xFF never appears.
- Underflow and clear:
  - Pop when empty → out_valid=0, data_out unchanged, err=1.
  - Assert clear_err → err=0 next cycle.
  - Assert clear_err in the same cycle as a second empty pop → err stays 1.
- Simultaneous push and pop:
  - With stack holding 0x10, 0x20 (top 0x20), push 0x30 and pop together → data_out=0x20, out_valid=1, count=2; a following pop returns 0x30.
  - With stack empty, push 0x44 and pop together → data_out=0x44, out_valid=1, count=0, err=0.
- RETURN_STACK_PEEK_EN build:
  - After push 0x9A → top=0x9A next cycle, count=1.
  - After pop → top=0, empty=1.
  - With the macro undefined, the top port is absent and the other scenarios pass unchanged.

Source files
------------

// File: rtl/return_stack.sv
// rtl/return_stack.sv - 8-entry LIFO of return addresses with sticky overflow/underflow flag
// Optional peek port "top" is enabled by defining RETURN_STACK_PEEK_EN.
module return_stack #(
  parameter int DATA_W = 8,
  parameter int PTR_W  = 3,
  parameter int DEPTH  = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] data_in,
  input  logic              clear_err,
  output logic [DATA_W-1:0] data_out,
  output logic              out_valid,
  output logic [PTR_W:0]    count,
  output logic              empty,
  output logic              full,
`ifdef RETURN_STACK_PEEK_EN
  output logic [DATA_W-1:0] top,
`endif
  output logic              err
);

  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W:0]    count_q, count_d;
  logic [DATA_W-1:0] data_out_q, data_out_d;
  logic              out_valid_q, out_valid_d;
  logic              err_q, err_d;
  logic              mem_we;
  logic [PTR_W-1:0]  mem_waddr;
  logic [PTR_W-1:0]  wr_idx, top_idx;
  logic              is_empty, is_full;

  // Low bits of count-1 equal low bits of count minus one, modulo the depth.
  assign wr_idx   = count_q[PTR_W-1:0];
  assign top_idx  = wr_idx - 1'b1;
  assign is_empty = (count_q == '0);
  assign is_full  = (count_q == FULL_CNT);

  always_comb begin
    count_d     = count_q;
    data_out_d  = data_out_q;
    out_valid_d = 1'b0;
    err_d       = err_q & ~clear_err;
    mem_we      = 1'b0;
    mem_waddr   = wr_idx;
    case ({push, pop})
      2'b10: begin
        if (is_full) begin
          err_d = 1'b1;
        end else begin
          mem_we  = 1'b1;
          count_d = count_q + 1'b1;
        end
      end
      2'b01: begin
        if (is_empty) begin
          err_d = 1'b1;
        end else begin
          data_out_d  = mem_q[top_idx];
          out_valid_d = 1'b1;
          count_d     = count_q - 1'b1;
        end
      end
      2'b11: begin
        out_valid_d = 1'b1;
        if (is_empty) begin
          data_out_d = data_in;
        end else begin
          data_out_d = mem_q[top_idx];
          mem_we     = 1'b1;
          mem_waddr  = top_idx;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      count_q     <= '0;
      data_out_q  <= '0;
      out_valid_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      count_q     <= count_d;
      data_out_q  <= data_out_d;
      out_valid_q <= out_valid_d;
      err_q       <= err_d;
    end
  end

  // Storage is deliberately not reset; reset only empties the stack logically.
  always_ff @(posedge clock) begin
    if (!reset && mem_we) begin
      mem_q[mem_waddr] <= data_in;
    end
  end

  assign data_out  = data_out_q;
  assign out_valid = out_valid_q;
  assign count     = count_q;
  assign empty     = is_empty;
  assign full      = is_full;
  assign err       = err_q;

`ifdef RETURN_STACK_PEEK_EN
  assign top = is_empty ? '0 : mem_q[top_idx];
`endif

endmodule

// File: tb/tb_return_stack.sv
// tb/tb_return_stack.sv - self-checking bench for return_stack against a queue model
module tb_return_stack;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       push = 1'b0;
  logic       pop = 1'b0;
  logic [7:0] data_in = '0;
  logic       clear_err = 1'b0;
  logic [7:0] data_out;
  logic       out_valid;
  logic [3:0] count;
  logic       empty;
  logic       full;
  logic       err;
`ifdef RETURN_STACK_PEEK_EN
  logic [7:0] top;
`endif

  int checks = 0;
  int failures = 0;

  return_stack #(.DATA_W(8), .PTR_W(3), .DEPTH(8)) dut (
    .clock(clock), .reset(reset), .push(push), .pop(pop), .data_in(data_in),
    .clear_err(clear_err), .data_out(data_out), .out_valid(out_valid),
    .count(count), .empty(empty), .full(full),
`ifdef RETURN_STACK_PEEK_EN
    .top(top),
`endif
    .err(err)
  );

  always #5 clock = ~clock;

  // Behavioural model: a queue whose back is the top of stack.
  logic [7:0] q[$];
  logic [7:0] m_dout = '0;
  logic       m_valid = 1'b0;
  logic       m_err = 1'b0;
  bit         model_ok = 1'b0;

  always @(posedge clock) begin
    if (reset) begin
      q.delete();
      m_dout = '0;
      m_valid = 1'b0;
      m_err = 1'b0;
      model_ok = 1'b1;
    end else begin
      m_valid = 1'b0;
      if (clear_err) m_err = 1'b0;
      if (push && pop) begin
        m_valid = 1'b1;
        if (q.size() == 0) begin
          m_dout = data_in;
        end else begin
          m_dout = q[q.size()-1];
          q[q.size()-1] = data_in;
        end
      end else if (push) begin
        if (q.size() == 8) m_err = 1'b1;
        else q.push_back(data_in);
      end else if (pop) begin
        if (q.size() == 0) m_err = 1'b1;
        else begin
          m_dout = q.pop_back();
          m_valid = 1'b1;
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clock) begin
    if (model_ok) begin
      check("cmp_count", 32'(count), 32'(q.size()));
      check("cmp_empty", 32'(empty), 32'(q.size() == 0));
      check("cmp_full", 32'(full), 32'(q.size() == 8));
      check("cmp_err", 32'(err), 32'(m_err));
      check("cmp_valid", 32'(out_valid), 32'(m_valid));
      check("cmp_dout", 32'(data_out), 32'(m_dout));
`ifdef RETURN_STACK_PEEK_EN
      check("cmp_top", 32'(top), (q.size() == 0) ? 32'h0 : 32'(q[q.size()-1]));
`endif
    end
  end

  task automatic cyc(input logic p, input logic o, input logic [7:0] d,
                     input logic c, input logic r);
    @(negedge clock);
    push = p; pop = o; data_in = d; clear_err = c; reset = r;
    @(posedge clock);
    #1;
    push = 1'b0; pop = 1'b0; clear_err = 1'b0; reset = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    cyc(0, 0, 8'h00, 0, 1);
    cyc(0, 0, 8'h00, 0, 1);
    check("reset_count", 32'(count), 0);
    check("reset_empty", 32'(empty), 1);

    // Reset mid-operation wins over a simultaneous push
    cyc(1, 0, 8'h11, 0, 0);
    cyc(1, 0, 8'h22, 0, 0);
    cyc(1, 0, 8'h33, 0, 1);
    check("midreset_count", 32'(count), 0);
    check("midreset_empty", 32'(empty), 1);
    check("midreset_err", 32'(err), 0);
    check("midreset_valid", 32'(out_valid), 0);
    check("midreset_dout", 32'(data_out), 0);

    // LIFO order
    cyc(1, 0, 8'h05, 0, 0);
    cyc(1, 0, 8'h06, 0, 0);
    cyc(1, 0, 8'h07, 0, 0);
    cyc(0, 1, 8'h00, 0, 0);
    check("order_pop1", 32'(data_out), 32'h07);
    check("order_valid1", 32'(out_valid), 1);
    cyc(0, 1, 8'h00, 0, 0);
    check("order_pop2", 32'(data_out), 32'h06);
    cyc(0, 1, 8'h00, 0, 0);
    check("order_pop3", 32'(data_out), 32'h05);
    cyc(0, 0, 8'h00, 0, 0);
    check("order_valid_drop", 32'(out_valid), 0);
    check("order_hold", 32'(data_out), 32'h05);
    check("order_empty", 32'(empty), 1);

    // Fill and overflow
    for (int i = 1; i <= 8; i++) cyc(1, 0, 8'(i), 0, 0);
    check("fill_full", 32'(full), 1);
    check("fill_count", 32'(count), 8);
    cyc(1, 0, 8'hFF, 0, 0);
    check("ovf_err", 32'(err), 1);
    check("ovf_count", 32'(count), 8);
    for (int i = 8; i >= 1; i--) begin
      cyc(0, 1, 8'h00, 0, 0);
      check("drain_dout", 32'(data_out), 32'(i));
    end
    check("drain_empty", 32'(empty), 1);
    cyc(0, 0, 8'h00, 1, 0);
    check("clr_err", 32'(err), 0);

    // Underflow and clear
    cyc(0, 1, 8'h00, 0, 0);
    check("udf_valid", 32'(out_valid), 0);
    check("udf_dout", 32'(data_out), 32'h01);
    check("udf_err", 32'(err), 1);
    cyc(0, 0, 8'h00, 1, 0);
    check("udf_clr", 32'(err), 0);
    cyc(0, 1, 8'h00, 1, 0);
    check("udf_clr_and_set", 32'(err), 1);
    cyc(0, 0, 8'h00, 1, 0);

    // Simultaneous push and pop
    cyc(1, 0, 8'h10, 0, 0);
    cyc(1, 0, 8'h20, 0, 0);
    cyc(1, 1, 8'h30, 0, 0);
    check("swap_dout", 32'(data_out), 32'h20);
    check("swap_valid", 32'(out_valid), 1);
    check("swap_count", 32'(count), 2);
    cyc(0, 1, 8'h00, 0, 0);
    check("swap_next", 32'(data_out), 32'h30);
    cyc(0, 1, 8'h00, 0, 0);
    check("swap_last", 32'(data_out), 32'h10);
    cyc(1, 1, 8'h44, 0, 0);
    check("pass_dout", 32'(data_out), 32'h44);
    check("pass_valid", 32'(out_valid), 1);
    check("pass_count", 32'(count), 0);
    check("pass_err", 32'(err), 0);

`ifdef RETURN_STACK_PEEK_EN
    cyc(1, 0, 8'h9A, 0, 0);
    check("peek_top", 32'(top), 32'h9A);
    check("peek_count", 32'(count), 1);
    cyc(0, 1, 8'h00, 0, 0);
    check("peek_top_zero", 32'(top), 0);
    check("peek_empty", 32'(empty), 1);
`endif

    // Randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      logic p, o, c, r;
      p = ($urandom_range(0, 99) < 50);
      o = ($urandom_range(0, 99) < 45);
      c = ($urandom_range(0, 99) < 8);
      r = ($urandom_range(0, 999) < 5);
      cyc(p, o, 8'($urandom), c, r);
    end
    cyc(0, 0, 8'h00, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
